// File: rtl/morse_game_pkg.sv
// Shared types and helpers for the Morse memory game controller.
package morse_game_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StArmed,
    StShow,
    StWait,
    StResult,
    StOver
  } state_e;

  localparam logic [1:0] LvlEasy = 2'd0;
  localparam logic [1:0] LvlMed  = 2'd1;
  localparam logic [1:0] LvlHard = 2'd2;

  localparam int unsigned LfsrW          = 16;
  localparam int unsigned MaxScoreDigits = 8;
  localparam int unsigned BcdW           = 4 * MaxScoreDigits;

  // Increment the low `digits` BCD digits of val; saturates at all-9s instead of wrapping.
  function automatic logic [BcdW-1:0] bcd_inc(input logic [BcdW-1:0] val,
                                               input int unsigned digits);
    logic [BcdW-1:0] res;
    logic            carry;
    logic            all9;
    res   = val;
    carry = 1'b1;
    all9  = 1'b1;
    for (int unsigned i = 0; i < MaxScoreDigits; i++) begin
      if (i < digits && val[4*i+:4] != 4'd9) all9 = 1'b0;
    end
    if (!all9) begin
      for (int unsigned i = 0; i < MaxScoreDigits; i++) begin
        if (i < digits && carry) begin
          if (res[4*i+:4] == 4'd9) begin
            res[4*i+:4] = 4'd0;
          end else begin
            res[4*i+:4] = res[4*i+:4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/morse_game_if.sv
// Handshake/status bundle between the game controller and its host.
interface morse_game_if #(
  parameter int unsigned DIGIT_W      = 4,
  parameter int unsigned SCORE_DIGITS = 2,
  parameter int unsigned MAX_MISSES   = 3
);
  localparam int unsigned MissW = $clog2(MAX_MISSES + 1);

  logic                      logged_in;
  logic                      game_start;
  logic                      load;
  logic [DIGIT_W-1:0]        user_input;
  logic [1:0]                level;
  logic                      logout;
  logic [DIGIT_W-1:0]        number;
  logic                      reconfig;
  logic                      enable;
  logic                      correct;
  logic [4*SCORE_DIGITS-1:0] score;
  logic [MissW-1:0]          misses;
  logic                      game_over;
  logic                      logout_req;

  modport master (
    output logged_in, game_start, load, user_input, level, logout,
    input  number, reconfig, enable, correct, score, misses, game_over, logout_req
  );

  modport slave (
    input  logged_in, game_start, load, user_input, level, logout,
    output number, reconfig, enable, correct, score, misses, game_over, logout_req
  );
endinterface

// File: rtl/morse_lfsr.sv
// Free-running maximal-length Galois LFSR, seeded with 1 (never reaches all-zero).
module morse_lfsr #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  output logic [Width-1:0] state_o
);

  // Maximal tap masks for widths 3..16; other widths fall back to a plain rotate.
  function automatic logic [31:0] tap_mask(input int unsigned w);
    case (w)
      3:       return 32'h0006;
      4:       return 32'h000C;
      5:       return 32'h0014;
      6:       return 32'h0030;
      7:       return 32'h0060;
      8:       return 32'h00B8;
      9:       return 32'h0110;
      10:      return 32'h0240;
      11:      return 32'h0500;
      12:      return 32'h0E08;
      13:      return 32'h1C80;
      14:      return 32'h3802;
      15:      return 32'h6000;
      16:      return 32'hB400;
      default: return 32'h1 << (w - 1);
    endcase
  endfunction

  localparam logic [31:0]      TapFull = tap_mask(Width);
  localparam logic [Width-1:0] Taps    = TapFull[Width-1:0];

  logic [Width-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q >> 1;
    if (lfsr_q[0]) lfsr_d = lfsr_d ^ Taps;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr_q <= Width'(1);
    else         lfsr_q <= lfsr_d;
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/morse_game_ctrl.sv
// Morse memory game sequencer: shows a target, times the answer window, keeps BCD score/misses.
module morse_game_ctrl
  import morse_game_pkg::*;
#(
  parameter int unsigned DIGIT_W      = 4,
  parameter int unsigned SCORE_DIGITS = 2,
  parameter int unsigned SHOW_TICKS   = 250_000_000,
  parameter int unsigned WIN_EASY     = 500_000_000,
  parameter int unsigned WIN_MED      = 250_000_000,
  parameter int unsigned WIN_HARD     = 100_000_000,
  parameter int unsigned MAX_MISSES   = 3
) (
  input logic         clk,
  input logic         rst,
  morse_game_if.slave game_io
);

  localparam int unsigned MaxWin   = (WIN_EASY > WIN_MED) ?
                                     ((WIN_EASY > WIN_HARD) ? WIN_EASY : WIN_HARD) :
                                     ((WIN_MED > WIN_HARD) ? WIN_MED : WIN_HARD);
  localparam int unsigned MaxTicks = (SHOW_TICKS > MaxWin) ? SHOW_TICKS : MaxWin;
  localparam int unsigned TimerW   = $clog2(MaxTicks + 1);
  localparam int unsigned ScoreW   = 4 * SCORE_DIGITS;
  localparam int unsigned MissW    = $clog2(MAX_MISSES + 1);

  state_e              state_q;
  logic [TimerW-1:0]   timer_q;
  logic [1:0]          level_q;
  logic [DIGIT_W-1:0]  number_q;
  logic [ScoreW-1:0]   score_q, score_d;
  logic [MissW-1:0]    misses_q;
  logic                reconfig_q, enable_q, correct_q, game_over_q, logout_req_q;
  logic [TimerW-1:0]   win_load;
  logic [BcdW-1:0]     score_inc;
  logic [LfsrW-1:0]    lfsr_state;
  logic                hit;
  logic                unused_lfsr;

  morse_lfsr #(
    .Width(LfsrW)
  ) u_lfsr (
    .clk_i  (clk),
    .rst_ni (rst),
    .state_o(lfsr_state)
  );

  assign unused_lfsr = ^lfsr_state[LfsrW-1:DIGIT_W];
  assign hit         = (game_io.user_input == number_q);

  always_comb begin
    score_inc = bcd_inc(BcdW'(score_q), SCORE_DIGITS);
    score_d   = score_inc[ScoreW-1:0];
  end

  // Level 3 shares the hard window.
  always_comb begin
    case (level_q)
      LvlEasy: win_load = TimerW'(WIN_EASY - 1);
      LvlMed:  win_load = TimerW'(WIN_MED - 1);
      default: win_load = TimerW'(WIN_HARD - 1);
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      timer_q      <= '0;
      level_q      <= LvlEasy;
      number_q     <= '0;
      score_q      <= '0;
      misses_q     <= '0;
      reconfig_q   <= 1'b0;
      enable_q     <= 1'b0;
      correct_q    <= 1'b0;
      game_over_q  <= 1'b0;
      logout_req_q <= 1'b0;
    end else begin
      reconfig_q   <= 1'b0;
      logout_req_q <= 1'b0;
      if (state_q != StIdle && (game_io.logout || !game_io.logged_in)) begin
        state_q      <= StIdle;
        timer_q      <= '0;
        enable_q     <= 1'b0;
        game_over_q  <= 1'b0;
        logout_req_q <= game_io.logout;
      end else begin
        unique case (state_q)
          StIdle: if (game_io.logged_in) state_q <= StArmed;
          StArmed: begin
            if (game_io.game_start) begin
              state_q    <= StShow;
              timer_q    <= TimerW'(SHOW_TICKS - 1);
              level_q    <= game_io.level;
              score_q    <= '0;
              misses_q   <= '0;
              correct_q  <= 1'b0;
              reconfig_q <= 1'b1;
              enable_q   <= 1'b1;
              number_q   <= lfsr_state[DIGIT_W-1:0];
            end
          end
          StShow: begin
            if (timer_q == '0) begin
              state_q  <= StWait;
              timer_q  <= win_load;
              enable_q <= 1'b0;
            end else begin
              timer_q <= timer_q - TimerW'(1);
            end
          end
          StWait: begin
            // A load on the expiry cycle still counts as an answer.
            if (game_io.load || timer_q == '0) begin
              state_q   <= StResult;
              timer_q   <= TimerW'(SHOW_TICKS - 1);
              correct_q <= game_io.load && hit;
              if (game_io.load && hit) score_q  <= score_d;
              else                     misses_q <= misses_q + MissW'(1);
            end else begin
              timer_q <= timer_q - TimerW'(1);
            end
          end
          StResult: begin
            if (timer_q != '0) begin
              timer_q <= timer_q - TimerW'(1);
            end else if (misses_q == MissW'(MAX_MISSES)) begin
              state_q     <= StOver;
              game_over_q <= 1'b1;
            end else begin
              state_q    <= StShow;
              timer_q    <= TimerW'(SHOW_TICKS - 1);
              reconfig_q <= 1'b1;
              enable_q   <= 1'b1;
              number_q   <= lfsr_state[DIGIT_W-1:0];
            end
          end
          StOver: begin
            if (!game_io.game_start) begin
              state_q     <= StArmed;
              game_over_q <= 1'b0;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign game_io.number     = number_q;
  assign game_io.reconfig   = reconfig_q;
  assign game_io.enable     = enable_q;
  assign game_io.correct    = correct_q;
  assign game_io.score      = score_q;
  assign game_io.misses     = misses_q;
  assign game_io.game_over  = game_over_q;
  assign game_io.logout_req = logout_req_q;

endmodule

// File: tb/tb_morse_game_ctrl.sv
// Randomised self-checking bench for morse_game_ctrl against a round-level game model.
module tb_morse_game_ctrl;

  localparam int unsigned ShowT = 4;
  localparam int unsigned WinE  = 8;
  localparam int unsigned WinM  = 6;
  localparam int unsigned WinH  = 3;
  localparam int unsigned MaxM  = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  morse_game_if #(.DIGIT_W(4), .SCORE_DIGITS(2), .MAX_MISSES(MaxM)) gif ();

  morse_game_ctrl #(
    .DIGIT_W     (4),
    .SCORE_DIGITS(2),
    .SHOW_TICKS  (ShowT),
    .WIN_EASY    (WinE),
    .WIN_MED     (WinM),
    .WIN_HARD    (WinH),
    .MAX_MISSES  (MaxM)
  ) dut (
    .clk    (clk),
    .rst    (rst_n),
    .game_io(gif)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int exp_score;
  int exp_misses;
  int lvl_m;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic int win_of(input int lvl);
    return (lvl == 0) ? WinE : (lvl == 1) ? WinM : WinH;
  endfunction

  function automatic logic [31:0] to_bcd(input int v);
    return 32'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic begin_model(input int lvl);
    exp_score  = 0;
    exp_misses = 0;
    lvl_m      = (lvl > 2) ? 2 : lvl;
    check_eq("start_score", gif.score, 0);
    check_eq("start_misses", gif.misses, 0);
    check_eq("start_enable", gif.enable, 1);
  endtask

  // Call from ARMED; returns on the first SHOW cycle.
  task automatic start_game(input int lvl);
    gif.level      = 2'(lvl);
    gif.game_start = 1'b1;
    tick();
    gif.game_start = 1'b0;
    check_eq("start_reconfig", gif.reconfig, 1);
    begin_model(lvl);
  endtask

  // Call on the reconfig cycle; returns on the next reconfig cycle or on entry to OVER.
  task automatic play_round(input bit do_load, input int delay, input bit right);
    logic [3:0] num;
    logic [3:0] ans;
    int         n;
    int         wlen;
    bit         hit;
    num = gif.number;
    n   = 0;
    while (gif.enable && n < 50) begin
      if (n > 0) check_eq("reconfig_once", gif.reconfig, 0);
      check_eq("number_stable", gif.number, num);
      n++;
      tick();
    end
    check_eq("show_len", n, ShowT);
    wlen = do_load ? delay + 1 : win_of(lvl_m);
    ans  = right ? num : (num ^ 4'($urandom_range(15, 1)));
    hit  = do_load && right;
    for (int i = 0; i < wlen; i++) begin
      gif.user_input = 4'($urandom);
      if (do_load && i == delay) begin
        gif.load       = 1'b1;
        gif.user_input = ans;
      end
      if (!do_load && i == wlen - 1) check_eq("misses_last_wait", gif.misses, exp_misses);
      tick();
      gif.load = 1'b0;
    end
    if (hit) begin
      if (exp_score < 99) exp_score++;
    end else begin
      exp_misses++;
    end
    check_eq("correct", gif.correct, 32'(hit));
    check_eq("score", gif.score, to_bcd(exp_score));
    check_eq("misses", gif.misses, exp_misses);
    // Stray strobe in RESULT must be ignored.
    gif.load       = 1'b1;
    gif.user_input = 4'($urandom);
    tick();
    gif.load = 1'b0;
    n = 1;
    while (!gif.reconfig && !gif.game_over && n < 50) begin
      tick();
      n++;
    end
    check_eq("result_len", n, ShowT);
    check_eq("correct_held", gif.correct, 32'(hit));
    check_eq("score_held", gif.score, to_bcd(exp_score));
    check_eq("game_over", gif.game_over, 32'(exp_misses == MaxM));
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_number"}, gif.number, 0);
    check_eq({tag, "_score"}, gif.score, 0);
    check_eq({tag, "_misses"}, gif.misses, 0);
    check_eq({tag, "_reconfig"}, gif.reconfig, 0);
    check_eq({tag, "_enable"}, gif.enable, 0);
    check_eq({tag, "_correct"}, gif.correct, 0);
    check_eq({tag, "_game_over"}, gif.game_over, 0);
    check_eq({tag, "_logout_req"}, gif.logout_req, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    gif.logged_in  = 1'b0;
    gif.game_start = 1'b0;
    gif.load       = 1'b0;
    gif.user_input = '0;
    gif.level      = '0;
    gif.logout     = 1'b0;
    repeat (2) tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();
    gif.logged_in = 1'b1;
    tick();

    // Level 1: correct on 2nd WAIT cycle, then three wrong answers end the game.
    start_game(1);
    play_round(1, 1, 1);
    for (int r = 0; r < 3; r++) begin
      gif.level = 2'($urandom);
      play_round(1, int'($urandom_range(WinM - 1)), 0);
    end
    check_eq("over_score_held", gif.score, 32'h01);
    tick();
    check_eq("over_to_armed", gif.game_over, 0);

    // Level 2: timeout, then load coinciding with expiry, then logout in WAIT.
    start_game(2);
    play_round(0, 0, 0);
    play_round(1, WinH - 1, 1);
    n = 0;
    while (gif.enable && n < 50) begin
      tick();
      n++;
    end
    gif.logout = 1'b1;
    tick();
    gif.logout = 1'b0;
    check_eq("logout_req", gif.logout_req, 1);
    check_eq("logout_enable", gif.enable, 0);
    check_eq("logout_score", gif.score, to_bcd(exp_score));
    check_eq("logout_misses", gif.misses, exp_misses);
    gif.level      = 2'd0;
    gif.game_start = 1'b1;
    tick();
    check_eq("logout_req_once", gif.logout_req, 0);
    check_eq("idle_then_armed", gif.reconfig, 0);
    tick();
    check_eq("restart_reconfig", gif.reconfig, 1);
    gif.game_start = 1'b0;
    begin_model(0);

    // Level 0: climb through 09->10 up to 99 and beyond (saturation).
    repeat (101) play_round(1, 0, 1);
    check_eq("score_saturated", gif.score, 32'h99);

    // Asynchronous reset in the middle of SHOW.
    tick();
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    gif.logged_in  = 1'b0;
    gif.game_start = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("idle_no_reconfig", gif.reconfig, 0);
      check_eq("idle_no_enable", gif.enable, 0);
    end
    gif.logged_in = 1'b1;
    gif.level     = 2'($urandom);
    tick();
    check_eq("login_armed", gif.reconfig, 0);
    tick();
    check_eq("login_start", gif.reconfig, 1);
    gif.game_start = 1'b0;
    begin_model(int'(gif.level));

    // Random games.
    for (int g = 0; g < 4; g++) begin
      int rounds;
      rounds = 0;
      while (exp_misses < MaxM) begin
        int  w;
        bit  dl;
        w  = win_of(lvl_m);
        dl = ($urandom_range(3) != 0) && rounds < 15;
        gif.level = 2'($urandom);
        play_round(dl, int'($urandom_range(w - 1)), bit'($urandom_range(1)));
        rounds++;
      end
      tick();
      check_eq("over_exit", gif.game_over, 0);
      if (g < 3) start_game(int'($urandom_range(3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/morse_game_ctrl.md
MORSE_GAME_CTRL -- requirements
Module: morse_game_ctrl

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- DIGIT_W, 4: width of target number and user_input.
- SCORE_DIGITS, 2: number of BCD score digits.
- SHOW_TICKS, 250_000_000: cycles the target is displayed.
- WIN_EASY, 500_000_000: input-window cycles, level 0.
- WIN_MED, 250_000_000: input-window cycles, level 1.
- WIN_HARD, 100_000_000: input-window cycles, level 2.
- MAX_MISSES, 3: misses that end the game.
REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, in, 1: single clock.
- rst, in, 1: asynchronous reset, active-low.
- logged_in, in, 1: user session valid.
- game_start, in, 1: level-sensitive start request.
- load, in, 1: one-cycle strobe committing user_input.
- user_input, in, DIGIT_W: user answer.
- level, in, 2: difficulty; 3 is treated as 2.
- number, out, DIGIT_W: current target.
- reconfig, out, 1: one-cycle pulse when a new target is issued.
- enable, out, 1: high in SHOW.
- correct, out, 1: last answer correct, valid in RESULT.
- score, out, 4*SCORE_DIGITS: packed BCD, digit 0 in LSBs.
- misses, out, clog2(MAX_MISSES+1): miss count.
- game_over, out, 1: high in OVER.
- logout, in, 1: logout request.
- logout_req, out, 1: one-cycle pulse forwarding an accepted logout.

Function
REQ-003 The FSM has states IDLE, ARMED, SHOW, WAIT, RESULT and OVER.
REQ-004 IDLE -> ARMED when logged_in=1.
REQ-005 ARMED -> SHOW when game_start=1; on this transition score and misses clear, the level is latched for the whole game, and reconfig pulses.
REQ-006 On the reconfig cycle, number loads the current LFSR value, masked to DIGIT_W; number is otherwise stable.
REQ-007 SHOW lasts exactly SHOW_TICKS cycles, then -> WAIT with the window counter loaded from the latched level.
REQ-008 In WAIT, the first load strobe ends the window; correct = (user_input == number); -> RESULT next cycle. Further load strobes are ignored until the next WAIT.
REQ-009 If the window expires with no load, correct=0 and a miss is counted; load and expiry in the same cycle count as load.
REQ-010 A correct answer increments score by 1 in BCD, carrying between digits. At all-9s, score saturates and does not wrap.
REQ-011 A wrong answer or a timeout increments misses.
REQ-012 RESULT lasts SHOW_TICKS cycles. It then goes -> OVER if misses == MAX_MISSES, else -> SHOW with a reconfig pulse and a new number.
REQ-013 OVER holds score and misses. It -> ARMED when game_start=0 and logged_in=1, and -> IDLE when logged_in=0.
REQ-014 logout=1 or logged_in=0 in any non-IDLE state -> IDLE next cycle, with timers cleared and score and misses held. logout_req pulses once if logout caused the exit.
REQ-015 The LFSR free-runs every cycle. An all-zero state is impossible.

Reset
REQ-016 With rst=0, the block asynchronously enters IDLE and holds all counters at 0.
REQ-017 Reset values: number=0, score=0, misses=0, reconfig=0, enable=0, correct=0, game_over=0, logout_req=0; the LFSR is seeded 1.
REQ-018 Reset deassertion mid-game restarts from IDLE; no state is retained.

Structure
REQ-019 A shared package holds the state enumeration, the level encodings (0/1/2) and the BCD increment function.
REQ-020 The single sub-module is morse_lfsr, a parametrised-width maximal LFSR, with the same reset convention.
REQ-021 The SHOW and RESULT dwell timers and the window timers share one down-counter sized for the largest tick parameter.

Verification
REQ-022 The bench overrides the tick parameters to SHOW=4, WIN_EASY=8, WIN_MED=6, WIN_HARD=3 and MAX_MISSES=3, and covers these scenarios:
- Login, then start at level 1, then load = number on the 2nd WAIT cycle -> correct=1 and score=0x01 in RESULT.
- No load at level 2 -> WAIT exits after exactly 3 cycles with correct=0 and misses=1.
- Three consecutive wrong answers -> game_over=1 after the 3rd RESULT, with score held.
- Score preset to 99, then a correct answer -> score stays 0x99; at 09 + correct -> 0x10.
- logout pulse during WAIT -> one-cycle logout_req, state IDLE next cycle.
- rst=0 asserted mid-SHOW -> outputs go to 0 immediately, asynchronously; after release the block waits in IDLE for logged_in.
